imp_cal_square: RTL and testbench



---
 rtl/imp_cal_square.sv | 152 +++++++++++++++
 tb/tb_imp_cal_square.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imp_cal_square.sv
// Sequential shift-add 8x8 squarer with floor-square-root check.
// Optional macro IMP_SQUARE_CHECK_EN enables the CHK state, o_rem and o_floor_ok.
module imp_cal_square (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [7:0]  i_root,
  input  logic [15:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_square,
  output logic [15:0] o_rem,
  output logic        o_floor_ok
);

`ifdef IMP_SQUARE_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, CHK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t      state_reg, state_next;
  logic [7:0]  root_reg, root_next;
  logic [15:0] acc_reg, acc_next;
  logic [2:0]  k_reg, k_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [15:0] square_reg, square_next;
  logic [15:0] addend;
  logic [15:0] acc_sum;

  // Partial product for the current bit; the sum never exceeds 255*255.
  assign addend  = root_reg[k_reg] ? ({8'd0, root_reg} << k_reg) : 16'd0;
  assign acc_sum = acc_reg + addend;

`ifdef IMP_SQUARE_CHECK_EN
  logic [15:0] data_reg, data_next;
  logic [15:0] rem_reg, rem_next;
  logic        ok_reg, ok_next;
  logic [16:0] next_square;
  logic        sq_le_data;
  logic        data_lt_next;

  // (R+1)^2 = S + 2R + 1 needs 17 bits when R = 255.
  assign next_square  = {1'b0, acc_reg} + {8'd0, root_reg, 1'b0} + 17'd1;
  assign sq_le_data   = (acc_reg <= data_reg);
  assign data_lt_next = ({1'b0, data_reg} < next_square);
`else
  logic unused_data;
  assign unused_data = ^i_data;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg  <= IDLE;
      root_reg   <= 8'd0;
      acc_reg    <= 16'd0;
      k_reg      <= 3'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      square_reg <= 16'd0;
`ifdef IMP_SQUARE_CHECK_EN
      data_reg   <= 16'd0;
      rem_reg    <= 16'd0;
      ok_reg     <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      root_reg   <= root_next;
      acc_reg    <= acc_next;
      k_reg      <= k_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      square_reg <= square_next;
`ifdef IMP_SQUARE_CHECK_EN
      data_reg   <= data_next;
      rem_reg    <= rem_next;
      ok_reg     <= ok_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    root_next   = root_reg;
    acc_next    = acc_reg;
    k_next      = k_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    square_next = square_reg;
`ifdef IMP_SQUARE_CHECK_EN
    data_next   = data_reg;
    rem_next    = rem_reg;
    ok_next     = ok_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          root_next  = i_root;
`ifdef IMP_SQUARE_CHECK_EN
          data_next  = i_data;
`endif
          acc_next   = 16'd0;
          k_next     = 3'd0;
          busy_next  = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        acc_next = acc_sum;
        k_next   = k_reg + 3'd1;
        if (k_reg == 3'd7) begin
`ifdef IMP_SQUARE_CHECK_EN
          state_next  = CHK;
`else
          // Without the checker the last product step is also the result edge.
          square_next = acc_sum;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
`endif
        end
      end
`ifdef IMP_SQUARE_CHECK_EN
      CHK: begin
        square_next = acc_reg;
        rem_next    = sq_le_data ? (data_reg - acc_reg) : 16'd0;
        ok_next     = sq_le_data && data_lt_next;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end
`endif
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign o_square = square_reg;
`ifdef IMP_SQUARE_CHECK_EN
  assign o_rem      = rem_reg;
  assign o_floor_ok = ok_reg;
`else
  assign o_rem      = 16'd0;
  assign o_floor_ok = 1'b0;
`endif

endmodule

// File: tb/tb_imp_cal_square.sv
// Directed self-checking bench for imp_cal_square; expectations follow IMP_SQUARE_CHECK_EN.
module tb_imp_cal_square;

  logic        i_clk;
  logic        i_rstn;
  logic        i_start;
  logic [7:0]  i_root;
  logic [15:0] i_data;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_square;
  logic [15:0] o_rem;
  logic        o_floor_ok;

`ifdef IMP_SQUARE_CHECK_EN
  localparam int LAT = 9;
  localparam bit CHK_EN = 1'b1;
`else
  localparam int LAT = 8;
  localparam bit CHK_EN = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  imp_cal_square dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (i_start),
    .i_root     (i_root),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_square   (o_square),
    .o_rem      (o_rem),
    .o_floor_ok (o_floor_ok)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // One operation; glitch>0 pulses a start with (5,25) before that edge after acceptance.
  task automatic run_op(input logic [7:0] r, input logic [15:0] d, input logic [15:0] sq,
                        input logic [15:0] rem, input logic ok, input int glitch);
    int n;
    bit seen;
    logic [15:0] exp_rem;
    logic        exp_ok;
    exp_rem = CHK_EN ? rem : 16'd0;
    exp_ok  = CHK_EN ? ok : 1'b0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_root  = r;
    i_data  = d;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_root  = ~r;
    i_data  = ~d;
    check("busy_after_accept", {31'd0, o_busy}, 32'd1);
    check("done_low_after_accept", {31'd0, o_done}, 32'd0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge i_clk);
      if (n + 1 == glitch) begin
        i_start = 1'b1;
        i_root  = 8'd5;
        i_data  = 16'd25;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      #1;
      n++;
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", n, LAT);
    check("busy_at_done", {31'd0, o_busy}, 32'd0);
    check("square", {16'd0, o_square}, {16'd0, sq});
    check("rem", {16'd0, o_rem}, {16'd0, exp_rem});
    check("floor_ok", {31'd0, o_floor_ok}, {31'd0, exp_ok});
    $display("op root=%0d data=%0d square=%0d rem=%0d ok=%0d latency=%0d",
             r, d, o_square, o_rem, o_floor_ok, n);
  endtask

  initial begin
    int dones;
    i_rstn  = 1'b0;
    i_start = 1'b0;
    i_root  = 8'd0;
    i_data  = 16'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_square", {16'd0, o_square}, 32'd0);
    check("reset_rem", {16'd0, o_rem}, 32'd0);
    check("reset_ok", {31'd0, o_floor_ok}, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Run one op first so reset visibly clears non-zero results.
    run_op(8'd31, 16'd1000, 16'd961, 16'd39, 1'b1, 0);

    // Reset asserted mid-multiply aborts the operation.
    @(negedge i_clk);
    i_start = 1'b1;
    i_root  = 8'd200;
    i_data  = 16'd40000;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_done", {31'd0, o_done}, 32'd0);
    check("midrst_square", {16'd0, o_square}, 32'd0);
    check("midrst_rem", {16'd0, o_rem}, 32'd0);
    check("midrst_ok", {31'd0, o_floor_ok}, 32'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_square_hold", {16'd0, o_square}, 32'd0);
    $display("op reset mid-MUL root=200 data=40000 dones_after=%0d", dones);

    // Back-to-back sequence, each start in the done cycle of the previous op.
    run_op(8'd63,  16'd4000,  16'd3969,  16'd31,  1'b1, 0);
    run_op(8'd31,  16'd1000,  16'd961,   16'd39,  1'b1, 0);
    run_op(8'd200, 16'd40000, 16'd40000, 16'd0,   1'b1, 0);
    run_op(8'd10,  16'd100,   16'd100,   16'd0,   1'b1, 0);
    run_op(8'd2,   16'd4,     16'd4,     16'd0,   1'b1, 0);

    // Non-floor candidates.
    run_op(8'd73,  16'd5326,  16'd5329,  16'd0,   1'b0, 0);
    run_op(8'd104, 16'd11094, 16'd10816, 16'd278, 1'b0, 0);
    run_op(8'd105, 16'd11094, 16'd11025, 16'd69,  1'b1, 0);

    // Boundaries.
    run_op(8'd255, 16'd65535, 16'd65025, 16'd510, 1'b1, 0);
    run_op(8'd0,   16'd0,     16'd0,     16'd0,   1'b1, 0);
    run_op(8'd0,   16'd1,     16'd0,     16'd1,   1'b0, 0);

    // Start while busy is ignored; start in the done cycle is accepted.
    run_op(8'd63,  16'd4000,  16'd3969,  16'd31,  1'b1, 3);
    run_op(8'd5,   16'd25,    16'd25,    16'd0,   1'b1, 0);

    // No stray pulse after the last op.
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) dones++;
    end
    check("idle_no_done", dones, 0);
    check("idle_square_hold", {16'd0, o_square}, 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
